cla16_word_sequencer: RTL

//  Sequential front/back end for the 16-bit structural CLA adder (cla_adder16).

---
 rtl/cla16_word_sequencer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/cla16_word_sequencer.sv
// Purpose: slices one wide add request into 16-bit steps for an external cla_adder16, carry chained through a register.
// Latency: out_valid rises NUM_SLICES clock edges after the accept edge; result held until consumed.
// Backpressure: in_ready low while running or while an unconsumed result waits; consume plus new request accepts back-to-back.
module cla16_word_sequencer #(
    parameter int NUM_SLICES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [16*NUM_SLICES-1:0]   op_a,
    input  logic [16*NUM_SLICES-1:0]   op_b,
    input  logic                       op_cin,
    output logic [15:0]                add_a,
    output logic [15:0]                add_b,
    output logic                       add_cin,
    input  logic [15:0]                add_sum,
    input  logic                       add_cout,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [16*NUM_SLICES-1:0]   result,
    output logic                       result_cout
);

    localparam int W  = 16 * NUM_SLICES;
    localparam int IW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_SLICES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [IW-1:0]  idx;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           cin_q;
    logic           carry;
    logic [IW+3:0]  base;
    logic           accept;

    // Bit offset of the slice currently being added.
    assign base = {idx, 4'b0000};

    // Handshake flags come straight from the state; in_ready stays low while reset is held.
    assign in_ready  = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a consume and a new request in the same cycle go straight back to RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (idx == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = in_valid ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Adder drive: current slice in RUN, quiet zeros otherwise; slice 0 takes the request carry.
    always_comb begin
        add_a   = 16'h0000;
        add_b   = 16'h0000;
        add_cin = 1'b0;
        if (state_q == RUN) begin
            add_a   = a_q[base +: 16];
            add_b   = b_q[base +: 16];
            add_cin = (idx == '0) ? cin_q : carry;
        end
    end

    // Datapath: capture operands on accept, then one sum slice per edge while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            idx         <= '0;
            carry       <= 1'b0;
            result      <= '0;
            result_cout <= 1'b0;
        end else if (accept) begin
            // Previous result stays visible until the first new slice lands.
            a_q   <= op_a;
            b_q   <= op_b;
            cin_q <= op_cin;
            idx   <= '0;
        end else if (state_q == RUN) begin
            result[base +: 16] <= add_sum;
            carry              <= add_cout;
            if (idx == LAST) begin
                result_cout <= add_cout;
                idx         <= '0;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

endmodule
